// File: rtl/fifo_async_param_if.sv
// Producer/consumer bundle for fifo_async_param: write side, read side and status.
// wr is taken on a wr_clk edge only while o_full is low; rd pops on an rd_clk edge only while o_empty is low; out is valid whenever o_empty is low.
interface fifo_async_param_if #(
   parameter int W  = 8,
   parameter int CW = 4
);
   logic          wr;
   logic [W-1:0]  in;
   logic          rd;
   logic [W-1:0]  out;
   logic          o_full;
   logic          o_almost_full;
   logic [CW-1:0] o_wr_count;
   logic          o_overflow;
   logic          o_empty;
   logic          o_almost_empty;
   logic [CW-1:0] o_rd_count;
   logic          o_underflow;

   modport master (
      output wr, in, rd,
      input  out, o_full, o_almost_full, o_wr_count, o_overflow,
             o_empty, o_almost_empty, o_rd_count, o_underflow
   );

   modport slave (
      input  wr, in, rd,
      output out, o_full, o_almost_full, o_wr_count, o_overflow,
             o_empty, o_almost_empty, o_rd_count, o_underflow
   );
endinterface

// File: rtl/fifo_async_param.sv
// Dual-clock FIFO, power-of-two depth, Gray pointers through 2-flop synchronisers,
// with occupancy counts, almost thresholds and sticky overflow/underflow.
module fifo_async_param #(
   parameter int bw         = 4,
   parameter int simd       = 1,
   parameter int depth_log2 = 3,
   parameter int af_margin  = 1,
   parameter int ae_margin  = 1
) (
   input logic reset,
   input logic rd_clk,
   input logic wr_clk,
   fifo_async_param_if.slave bus
);
   localparam int W     = simd * bw;
   localparam int DEPTH = 1 << depth_log2;
   localparam int PW    = depth_log2 + 1;

   typedef logic [PW-1:0] ptr_t;

   function automatic ptr_t bin2gray(input ptr_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   logic [W-1:0] mem [DEPTH];

   ptr_t wr_ptr, wr_gray, rd_gray_s1, rd_gray_s2;
   ptr_t rd_ptr, rd_gray, wr_gray_s1, wr_gray_s2;
   ptr_t wr_ptr_nxt, rd_ptr_nxt, wr_count, rd_count;
   logic full, empty, wr_en, rd_en, overflow, underflow;

   // Flags compare against the lagging remote pointer, so they can only be pessimistic.
   assign full       = (wr_gray == {~rd_gray_s2[PW-1:PW-2], rd_gray_s2[PW-3:0]});
   assign empty      = (rd_gray == wr_gray_s2);
   assign wr_en      = bus.wr && !full;
   assign rd_en      = bus.rd && !empty;
   assign wr_ptr_nxt = wr_ptr + ptr_t'(1);
   assign rd_ptr_nxt = rd_ptr + ptr_t'(1);
   assign wr_count   = wr_ptr - gray2bin(rd_gray_s2);
   assign rd_count   = gray2bin(wr_gray_s2) - rd_ptr;

   always_ff @(posedge wr_clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         wr_gray  <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr[depth_log2-1:0]] <= bus.in;
            wr_ptr  <= wr_ptr_nxt;
            wr_gray <= bin2gray(wr_ptr_nxt);
         end
         if (bus.wr && full) overflow <= 1'b1;
      end
   end

   always_ff @(posedge wr_clk or posedge reset) begin
      if (reset) begin
         rd_gray_s1 <= '0;
         rd_gray_s2 <= '0;
      end else begin
         rd_gray_s1 <= rd_gray;
         rd_gray_s2 <= rd_gray_s1;
      end
   end

   always_ff @(posedge rd_clk or posedge reset) begin
      if (reset) begin
         rd_ptr    <= '0;
         rd_gray   <= '0;
         underflow <= 1'b0;
      end else begin
         if (rd_en) begin
            rd_ptr  <= rd_ptr_nxt;
            rd_gray <= bin2gray(rd_ptr_nxt);
         end
         if (bus.rd && empty) underflow <= 1'b1;
      end
   end

   always_ff @(posedge rd_clk or posedge reset) begin
      if (reset) begin
         wr_gray_s1 <= '0;
         wr_gray_s2 <= '0;
      end else begin
         wr_gray_s1 <= wr_gray;
         wr_gray_s2 <= wr_gray_s1;
      end
   end

   always_comb begin
      bus.out            = mem[rd_ptr[depth_log2-1:0]];
      bus.o_full         = full;
      bus.o_almost_full  = (wr_count >= ptr_t'(DEPTH - af_margin));
      bus.o_wr_count     = wr_count;
      bus.o_overflow     = overflow;
      bus.o_empty        = empty;
      bus.o_almost_empty = (rd_count <= ptr_t'(ae_margin));
      bus.o_rd_count     = rd_count;
      bus.o_underflow    = underflow;
   end
endmodule

// File: tb/tb_fifo_async_param.sv
// Bench for fifo_async_param: fill/drain, random wrap, underflow, thresholds,
// crossing latency at several clock ratios and reset during traffic.
`timescale 1ns/1ps
module tb_fifo_async_param;
   localparam int W     = 8;
   localparam int CW    = 4;
   localparam int DEPTH = 8;

   logic reset  = 1'b1;
   logic rd_clk = 1'b0;
   logic wr_clk = 1'b0;
   int   wr_half = 5;
   int   rd_half = 7;

   logic [W-1:0] exp_q[$];
   int vectors = 0;
   int errors  = 0;

   fifo_async_param_if #(.W(W), .CW(CW)) bus ();

   fifo_async_param #(
      .bw(4), .simd(2), .depth_log2(3), .af_margin(2), .ae_margin(1)
   ) dut (
      .reset (reset),
      .rd_clk(rd_clk),
      .wr_clk(wr_clk),
      .bus   (bus)
   );

   // clock / reset
   initial forever begin #(wr_half); wr_clk = ~wr_clk; end
   initial forever begin #(rd_half); rd_clk = ~rd_clk; end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time exceeded, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic apply_reset();
      bus.wr = 1'b0;
      bus.rd = 1'b0;
      reset  = 1'b1;
      exp_q.delete();
      #30;
      @(negedge wr_clk);
      reset = 1'b0;
      repeat (2) @(negedge rd_clk);
   endtask

   // drivers
   task automatic push(input logic [W-1:0] d, output bit acc);
      @(negedge wr_clk);
      acc    = !bus.o_full;
      bus.in = d;
      bus.wr = 1'b1;
      @(posedge wr_clk);
      #1;
      bus.wr = 1'b0;
   endtask

   task automatic pop(output logic [W-1:0] d, output bit ok);
      @(negedge rd_clk);
      ok     = !bus.o_empty;
      d      = bus.out;
      bus.rd = ok;
      @(posedge rd_clk);
      #1;
      bus.rd = 1'b0;
   endtask

   task automatic settle();
      repeat (4) @(posedge wr_clk);
      repeat (4) @(posedge rd_clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #3;
      vectors++; if (bus.o_empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %0b expected 1", bus.o_empty); end
      vectors++; if (bus.o_almost_empty !== 1'b1) begin errors++; $display("FAIL rst_aempty: got %0b expected 1", bus.o_almost_empty); end
      vectors++; if (bus.o_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %0b expected 0", bus.o_full); end
      vectors++; if (bus.o_almost_full !== 1'b0) begin errors++; $display("FAIL rst_afull: got %0b expected 0", bus.o_almost_full); end
      vectors++; if (bus.o_wr_count !== 4'd0 || bus.o_rd_count !== 4'd0) begin errors++; $display("FAIL rst_counts: got %0d/%0d expected 0/0", bus.o_wr_count, bus.o_rd_count); end
      vectors++; if (bus.o_overflow !== 1'b0 || bus.o_underflow !== 1'b0) begin errors++; $display("FAIL rst_sticky: got %0b%0b expected 00", bus.o_overflow, bus.o_underflow); end
      vectors++; if (bus.out !== 8'h00) begin errors++; $display("FAIL rst_out: got %0h expected 0", bus.out); end
      apply_reset();
      vectors++; if (bus.o_empty !== 1'b1 || bus.o_rd_count !== 4'd0) begin errors++; $display("FAIL rst_release: got empty=%0b cnt=%0d expected 1/0", bus.o_empty, bus.o_rd_count); end
   endtask

   task automatic test_fill_drain();
      bit acc, ok;
      logic [W-1:0] d, e;
      apply_reset();
      for (int i = 1; i <= DEPTH; i++) begin
         push(W'(i), acc);
         if (acc) exp_q.push_back(W'(i));
      end
      vectors++; if (bus.o_full !== 1'b1) begin errors++; $display("FAIL fill_full: got %0b expected 1", bus.o_full); end
      vectors++; if (bus.o_wr_count !== 4'd8) begin errors++; $display("FAIL fill_wr_count: got %0d expected 8", bus.o_wr_count); end
      push(8'hFF, acc);
      vectors++; if (acc !== 1'b0) begin errors++; $display("FAIL fill_ninth_accepted: got %0b expected 0", acc); end
      vectors++; if (bus.o_overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow: got %0b expected 1", bus.o_overflow); end
      vectors++; if (bus.o_wr_count !== 4'd8) begin errors++; $display("FAIL fill_count_hold: got %0d expected 8", bus.o_wr_count); end
      settle();
      for (int i = 1; i <= DEPTH; i++) begin
         pop(d, ok);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         vectors++; if (ok !== 1'b1 || d !== e) begin errors++; $display("FAIL drain_data: got %0h (ok=%0b) expected %0h", d, ok, e); end
      end
      vectors++; if (bus.o_empty !== 1'b1 || bus.o_rd_count !== 4'd0) begin errors++; $display("FAIL drain_empty: got empty=%0b cnt=%0d expected 1/0", bus.o_empty, bus.o_rd_count); end
   endtask

   task automatic test_wrap();
      bit acc, ok;
      int np, nr, guard;
      logic [W-1:0] d, r, e;
      apply_reset();
      for (int round = 0; round < 20; round++) begin
         np = $urandom_range(1, 6);
         for (int k = 0; k < np; k++) begin
            r = W'($urandom_range(0, 255));
            push(r, acc);
            if (acc) begin
               vectors++; if (exp_q.size() >= DEPTH) begin errors++; $display("FAIL wrap_false_notfull: got accepted at size %0d expected full", exp_q.size()); end
               exp_q.push_back(r);
            end
         end
         nr = $urandom_range(1, 6);
         for (int k = 0; k < nr; k++) begin
            pop(d, ok);
            if (ok) begin
               vectors++;
               if (exp_q.size() == 0) begin errors++; $display("FAIL wrap_false_notempty: got pop %0h expected empty", d); end
               else begin
                  e = exp_q.pop_front();
                  if (d !== e) begin errors++; $display("FAIL wrap_data: got %0h expected %0h", d, e); end
               end
            end
         end
         if (round % 5 == 4) begin
            settle();
            vectors++;
            if (bus.o_empty !== (exp_q.size() == 0) || bus.o_full !== (exp_q.size() == DEPTH) ||
                bus.o_rd_count !== CW'(exp_q.size()) || bus.o_wr_count !== CW'(exp_q.size())) begin
               errors++;
               $display("FAIL wrap_settled: got e=%0b f=%0b rc=%0d wc=%0d expected size %0d", bus.o_empty, bus.o_full, bus.o_rd_count, bus.o_wr_count, exp_q.size());
            end
         end
      end
      settle();
      guard = 0;
      while (!bus.o_empty && guard < 2 * DEPTH) begin
         pop(d, ok);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         vectors++; if (d !== e) begin errors++; $display("FAIL wrap_drain: got %0h expected %0h", d, e); end
         guard++;
      end
      vectors++; if (exp_q.size() != 0 || bus.o_underflow !== 1'b0) begin errors++; $display("FAIL wrap_leftover: got %0d left uf=%0b expected 0/0", exp_q.size(), bus.o_underflow); end
   endtask

   task automatic test_underflow();
      bit acc, ok;
      logic [W-1:0] d;
      apply_reset();
      @(negedge rd_clk);
      bus.rd = 1'b1;
      repeat (3) @(posedge rd_clk);
      #1;
      bus.rd = 1'b0;
      vectors++; if (bus.o_underflow !== 1'b1) begin errors++; $display("FAIL uf_flag: got %0b expected 1", bus.o_underflow); end
      vectors++; if (bus.o_empty !== 1'b1 || bus.o_rd_count !== 4'd0) begin errors++; $display("FAIL uf_ptr_hold: got empty=%0b cnt=%0d expected 1/0", bus.o_empty, bus.o_rd_count); end
      push(8'h5A, acc);
      if (acc) exp_q.push_back(8'h5A);
      settle();
      vectors++; if (bus.o_rd_count !== 4'd1) begin errors++; $display("FAIL uf_count: got %0d expected 1", bus.o_rd_count); end
      pop(d, ok);
      vectors++; if (ok !== 1'b1 || d !== 8'h5A) begin errors++; $display("FAIL uf_readback: got %0h expected 5a", d); end
      exp_q.delete();
   endtask

   task automatic test_thresholds();
      bit acc, ok;
      logic [W-1:0] d, e, r;
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         r = W'($urandom_range(0, 255));
         push(r, acc);
         if (acc) exp_q.push_back(r);
      end
      vectors++; if (bus.o_almost_full !== 1'b0 || bus.o_wr_count !== 4'd5) begin errors++; $display("FAIL thr_af5: got af=%0b cnt=%0d expected 0/5", bus.o_almost_full, bus.o_wr_count); end
      r = W'($urandom_range(0, 255));
      push(r, acc);
      if (acc) exp_q.push_back(r);
      vectors++; if (bus.o_almost_full !== 1'b1) begin errors++; $display("FAIL thr_af6: got %0b expected 1", bus.o_almost_full); end
      settle();
      vectors++; if (bus.o_rd_count !== 4'd6 || bus.o_almost_empty !== 1'b0) begin errors++; $display("FAIL thr_rd6: got cnt=%0d ae=%0b expected 6/0", bus.o_rd_count, bus.o_almost_empty); end
      for (int i = 0; i < 4; i++) begin
         pop(d, ok);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         vectors++; if (d !== e) begin errors++; $display("FAIL thr_data: got %0h expected %0h", d, e); end
      end
      vectors++; if (bus.o_rd_count !== 4'd2 || bus.o_almost_empty !== 1'b0) begin errors++; $display("FAIL thr_ae2: got cnt=%0d ae=%0b expected 2/0", bus.o_rd_count, bus.o_almost_empty); end
      pop(d, ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      vectors++; if (bus.o_almost_empty !== 1'b1 || d !== e) begin errors++; $display("FAIL thr_ae1: got ae=%0b d=%0h expected 1/%0h", bus.o_almost_empty, d, e); end
   endtask

   task automatic test_latency(input int wh, input int rh);
      int  n;
      bit  seen;
      time tw;
      wr_half = wh;
      rd_half = rh;
      apply_reset();
      @(negedge wr_clk);
      bus.in = 8'hA5;
      bus.wr = 1'b1;
      @(posedge wr_clk);
      tw = $time;
      fork begin #1; bus.wr = 1'b0; end join_none
      n = 0;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(posedge rd_clk);
         if ($time != tw) begin
            n++;
            #1;
            if (!bus.o_empty) seen = 1'b1;
         end
      end
      vectors++; if (!seen || n < 2 || n > 3) begin errors++; $display("FAIL latency_%0d_%0d: got edge %0d (seen=%0b) expected 2..3", wh, rh, n, seen); end
      vectors++; if (bus.o_rd_count !== 4'd1 || bus.out !== 8'hA5) begin errors++; $display("FAIL latency_data_%0d_%0d: got cnt=%0d out=%0h expected 1/a5", wh, rh, bus.o_rd_count, bus.out); end
   endtask

   task automatic test_reset_mid();
      bit acc, ok;
      logic [W-1:0] d, e, r;
      apply_reset();
      for (int i = 0; i < DEPTH + 1; i++) begin
         r = W'($urandom_range(0, 255));
         push(r, acc);
         if (acc) exp_q.push_back(r);
      end
      vectors++; if (bus.o_overflow !== 1'b1) begin errors++; $display("FAIL mid_overflow: got %0b expected 1", bus.o_overflow); end
      settle();
      for (int i = 0; i < 3; i++) begin
         pop(d, ok);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         vectors++; if (d !== e) begin errors++; $display("FAIL mid_data: got %0h expected %0h", d, e); end
      end
      vectors++; if (bus.o_rd_count !== 4'd5) begin errors++; $display("FAIL mid_queued: got %0d expected 5", bus.o_rd_count); end
      @(negedge wr_clk);
      #1;
      reset = 1'b1;
      exp_q.delete();
      #2;
      vectors++; if (bus.o_empty !== 1'b1 || bus.o_full !== 1'b0) begin errors++; $display("FAIL mid_rst_flags: got e=%0b f=%0b expected 1/0", bus.o_empty, bus.o_full); end
      vectors++; if (bus.o_wr_count !== 4'd0 || bus.o_rd_count !== 4'd0) begin errors++; $display("FAIL mid_rst_counts: got %0d/%0d expected 0/0", bus.o_wr_count, bus.o_rd_count); end
      vectors++; if (bus.o_overflow !== 1'b0 || bus.o_underflow !== 1'b0) begin errors++; $display("FAIL mid_rst_sticky: got %0b%0b expected 00", bus.o_overflow, bus.o_underflow); end
      vectors++; if (bus.out !== 8'h00) begin errors++; $display("FAIL mid_rst_out: got %0h expected 0", bus.out); end
      #20;
      @(negedge wr_clk);
      reset = 1'b0;
      push(8'h3C, acc);
      if (acc) exp_q.push_back(8'h3C);
      settle();
      pop(d, ok);
      vectors++; if (ok !== 1'b1 || d !== 8'h3C) begin errors++; $display("FAIL mid_readback: got %0h expected 3c", d); end
   endtask

   initial begin
      bus.wr = 1'b0;
      bus.rd = 1'b0;
      bus.in = '0;
      test_reset();
      test_fill_drain();
      test_wrap();
      test_underflow();
      test_thresholds();
      test_reset_mid();
      test_latency(5, 5);
      test_latency(5, 15);
      test_latency(15, 5);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
